// File: rtl/tabla_lut_seq.sv
// tabla_lut_seq: run-time loadable N-input truth table with registered output
// and a built-in sweep sequencer that walks every index and captures the
// resulting output column.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   wr_en/wr_data  load the whole table (accepted only in IDLE)
//   in_valid/sel   one lookup of table[sel] (accepted only in IDLE)
//   sweep_start    run a full 0..2^N-1 sweep (accepted only in IDLE)
//   y/y_valid/y_idx  registered result, one-cycle valid pulse, source index
//   sweep_busy     high in SWEEP and DONE
//   sweep_done     one-cycle pulse in DONE
//   sweep_sig      output column captured by the last sweep
module tabla_lut_seq #(
    parameter int              N          = 3,
    parameter logic [2**N-1:0] TABLE_INIT = 8'h96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2**N-1:0]   wr_data,
    input  logic              in_valid,
    input  logic [N-1:0]      sel,
    input  logic              sweep_start,
    output logic              y,
    output logic              y_valid,
    output logic [N-1:0]      y_idx,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic [2**N-1:0]   sweep_sig
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

    logic [1:0]      state;
    logic [N-1:0]    idx;
    logic [2**N-1:0] tbl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            tbl       <= TABLE_INIT;
            y         <= 1'b0;
            y_valid   <= 1'b0;
            y_idx     <= '0;
            sweep_sig <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A write lands at this edge; a same-cycle lookup still
                    // reads the old table, a same-cycle sweep reads the new
                    // one from its first SWEEP cycle onward.
                    if (wr_en)
                        tbl <= wr_data;
                    if (sweep_start) begin
                        // Sweep wins over a concurrent lookup.
                        state     <= S_SWEEP;
                        idx       <= '0;
                        sweep_sig <= '0;
                        y_valid   <= 1'b0;
                    end else if (in_valid) begin
                        y       <= tbl[sel];
                        y_idx   <= sel;
                        y_valid <= 1'b1;
                    end else begin
                        y_valid <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    y              <= tbl[idx];
                    y_idx          <= idx;
                    y_valid        <= 1'b1;
                    sweep_sig[idx] <= tbl[idx];
                    // Stop at the last index instead of wrapping.
                    if (idx == IDX_LAST)
                        state <= S_DONE;
                    else
                        idx <= idx + 1'b1;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    y_valid <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_busy = (state != S_IDLE);
    assign sweep_done = (state == S_DONE);

endmodule
